// File: rtl/alu_exec_unit.sv
// Execute-stage ALU for the RV32IM core: single-cycle arithmetic/logic/multiply,
// iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, registered result.
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  busy,
  output logic                  o_dbg_state
);
  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(W);
  localparam logic [SW-1:0] LAST_STEP = SW'(W - 1);
  localparam logic [W-1:0]  MOST_NEG  = {1'b1, {(W-1){1'b0}}};

  localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_MUL = 5'b00010,
                         OP_MULH = 5'b00011, OP_MULHSU = 5'b00100, OP_MULHU = 5'b00101,
                         OP_DIV = 5'b00110, OP_DIVU = 5'b00111, OP_REM = 5'b01000,
                         OP_REMU = 5'b01001, OP_XOR = 5'b01010, OP_OR = 5'b01011,
                         OP_AND = 5'b01100, OP_SLL = 5'b01101, OP_SRL = 5'b01110,
                         OP_SRA = 5'b01111, OP_SLT = 5'b10000, OP_SLTU = 5'b10001,
                         OP_EQ = 5'b10010, OP_NE = 5'b10011;

  typedef enum logic {IDLE = 1'b0, DIV_RUN = 1'b1} state_t;

  state_t        r_state, w_state_next;
  logic          r_out_valid, r_zero;
  logic [W-1:0]  r_result;
  logic [SW-1:0] r_count;
  logic [W-1:0]  r_quo, r_rem, r_divisor;
  logic          r_neg_q, r_neg_r, r_is_rem;

  logic          w_accept, w_is_div, w_is_signed, w_div_special, w_start_div;
  logic [2*W-1:0] w_a_ext, w_b_ext, w_prod;
  logic [SW-1:0] w_shamt;
  logic [W-1:0]  w_single, w_abs_a, w_abs_b;
  logic [W:0]    w_shift, w_trial;
  logic          w_q_bit;
  logic [W-1:0]  w_quo_next, w_rem_next, w_div_final;

  // Handshake: a request transfers on an edge where in_valid && in_ready; a result
  // transfers on an edge where out_valid && out_ready. in_ready/busy depend only on
  // registered state, and outputs hold while out_valid && !out_ready.
  assign in_ready    = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign busy        = (r_state == DIV_RUN);
  assign o_dbg_state = (r_state == DIV_RUN);
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign zero        = r_zero;
  assign w_accept    = in_valid && in_ready;

  assign w_is_div      = (alu_ctrl == OP_DIV) || (alu_ctrl == OP_DIVU) ||
                         (alu_ctrl == OP_REM) || (alu_ctrl == OP_REMU);
  assign w_is_signed   = (alu_ctrl == OP_DIV) || (alu_ctrl == OP_REM);
  assign w_div_special = (op_b == '0) || (w_is_signed && (op_a == MOST_NEG) && (op_b == '1));
  assign w_start_div   = w_is_div && !w_div_special;

  // One shared multiplier; operand extension selects signed/unsigned interpretation.
  always_comb begin
    w_a_ext = {{W{1'b0}}, op_a};
    w_b_ext = {{W{1'b0}}, op_b};
    if (alu_ctrl == OP_MULH || alu_ctrl == OP_MULHSU) w_a_ext = {{W{op_a[W-1]}}, op_a};
    if (alu_ctrl == OP_MULH) w_b_ext = {{W{op_b[W-1]}}, op_b};
  end
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_shamt = op_b[SW-1:0];

  always_comb begin
    w_single = '0;
    case (alu_ctrl)
      OP_ADD:    w_single = op_a + op_b;
      OP_SUB:    w_single = op_a - op_b;
      OP_MUL:    w_single = w_prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_single = w_prod[2*W-1:W];
      OP_DIV, OP_DIVU: w_single = (op_b == '0) ? '1 : op_a;
      OP_REM, OP_REMU: w_single = (op_b == '0) ? op_a : '0;
      OP_XOR:    w_single = op_a ^ op_b;
      OP_OR:     w_single = op_a | op_b;
      OP_AND:    w_single = op_a & op_b;
      OP_SLL:    w_single = op_a << w_shamt;
      OP_SRL:    w_single = op_a >> w_shamt;
      OP_SRA:    w_single = $signed(op_a) >>> w_shamt;
      OP_SLT:    w_single = {{(W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU:   w_single = {{(W-1){1'b0}}, op_a < op_b};
      OP_EQ:     w_single = {{(W-1){1'b0}}, op_a == op_b};
      OP_NE:     w_single = {{(W-1){1'b0}}, op_a != op_b};
      default:   w_single = '0;
    endcase
  end

  assign w_abs_a = (w_is_signed && op_a[W-1]) ? -op_a : op_a;
  assign w_abs_b = (w_is_signed && op_b[W-1]) ? -op_b : op_b;

  // Restoring step: bit W of the trial difference is the borrow.
  assign w_shift     = {r_rem, r_quo[W-1]};
  assign w_trial     = w_shift - {1'b0, r_divisor};
  assign w_q_bit     = ~w_trial[W];
  assign w_rem_next  = w_q_bit ? w_trial[W-1:0] : w_shift[W-1:0];
  assign w_quo_next  = {r_quo[W-2:0], w_q_bit};
  assign w_div_final = r_is_rem ? (r_neg_r ? -w_rem_next : w_rem_next)
                                : (r_neg_q ? -w_quo_next : w_quo_next);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_start_div) w_state_next = DIV_RUN;
      DIV_RUN: if (r_count == LAST_STEP) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_count     <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_divisor   <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_is_rem    <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_accept && !w_start_div) begin
        r_out_valid <= 1'b1;
        r_result    <= w_single;
        r_zero      <= (w_single == '0);
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
        r_quo       <= w_abs_a;
        r_rem       <= '0;
        r_divisor   <= w_abs_b;
        r_neg_q     <= w_is_signed && (op_a[W-1] ^ op_b[W-1]);
        r_neg_r     <= w_is_signed && op_a[W-1];
        r_is_rem    <= (alu_ctrl == OP_REM) || (alu_ctrl == OP_REMU);
        r_count     <= '0;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end else begin
      r_quo   <= w_quo_next;
      r_rem   <= w_rem_next;
      r_count <= r_count + SW'(1);
      if (r_count == LAST_STEP) begin
        r_out_valid <= 1'b1;
        r_result    <= w_div_final;
        r_zero      <= (w_div_final == '0);
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, expected-result queue
// drained by an output monitor, latency/busy/backpressure/reset-abort checks.
module tb_alu_exec_unit;
  localparam int W = 32;

  localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_MUL = 5'b00010,
                         OP_MULH = 5'b00011, OP_MULHSU = 5'b00100, OP_MULHU = 5'b00101,
                         OP_DIV = 5'b00110, OP_DIVU = 5'b00111, OP_REM = 5'b01000,
                         OP_REMU = 5'b01001, OP_XOR = 5'b01010, OP_OR = 5'b01011,
                         OP_AND = 5'b01100, OP_SLL = 5'b01101, OP_SRL = 5'b01110,
                         OP_SRA = 5'b01111, OP_SLT = 5'b10000, OP_SLTU = 5'b10001,
                         OP_EQ = 5'b10010, OP_NE = 5'b10011, OP_RSVD = 5'b10100;

  logic         clk, reset, in_valid, in_ready, out_valid, out_ready, zero, busy, dbg_state;
  logic [4:0]   alu_ctrl;
  logic [W-1:0] op_a, op_b, result;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           lat_q[$];
  int           acc_q[$];

  alu_exec_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .busy(busy),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // scoreboard: every transferred result is compared against the oldest expectation
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      check("spurious_out", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [W-1:0] e;
        string        t;
        int           l, a;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        l = lat_q.pop_front();
        a = acc_q.pop_front();
        check({t, "_result"}, result, e);
        check({t, "_zero"}, 32'(zero), 32'(e == '0));
        if (l != 0) check({t, "_latency"}, 32'(cyc - a), 32'(l));
      end
    end
  end

  // driver: present a request, wait (bounded) for in_ready, record expectation
  task automatic send(input string tag, input logic [4:0] c, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] e, input int lat);
    int n = 0;
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, 32'(in_ready), 32'd1);
    if (in_ready) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
      lat_q.push_back(lat);
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_div(input string tag, input logic [4:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] e, input int exp_busy);
    int nb  = 0;
    int bad = 0;
    send(tag, c, a, b, e, (exp_busy != 0) ? 33 : 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) begin
        nb++;
        if (in_ready) bad++;
      end
    end
    check({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
    check({tag, "_ready_low"}, 32'(bad), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_ctrl  = '0;
    op_a      = '0;
    op_b      = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // back-to-back single-cycle ops
    send("add",    OP_ADD,  32'd7,         32'hFFFF_FFFD, 32'd4,         1);
    send("sub",    OP_SUB,  32'd5,         32'd5,         32'd0,         1);
    send("sra",    OP_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000, 1);
    send("sltu",   OP_SLTU, 32'd1,         32'hFFFF_FFFF, 32'd1,         1);
    send("xor",    OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
    send("or",     OP_OR,   32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1);
    send("and",    OP_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1);
    send("sll",    OP_SLL,  32'd1,         32'd31,        32'h8000_0000, 1);
    send("sll_hi", OP_SLL,  32'd1,         32'h0000_0021, 32'd2,         1);
    send("srl",    OP_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000, 1);
    send("slt",    OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         1);
    send("eq",     OP_EQ,   32'd5,         32'd5,         32'd1,         1);
    send("ne",     OP_NE,   32'd5,         32'd5,         32'd0,         1);
    send("rsvd",   OP_RSVD, 32'd5,         32'd5,         32'd0,         1);
    send("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
    send("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    send("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
    send("mul",    OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1);
    repeat (2) @(posedge clk);
    #1;

    // iterative divides, then single-cycle special cases
    run_div("div_neg",  OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32);
    run_div("rem_neg",  OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32);
    run_div("divu",     OP_DIVU, 32'd100,       32'd7,         32'd14,        32);
    run_div("remu",     OP_REMU, 32'd100,       32'd7,         32'd2,         32);
    run_div("div_negb", OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32);
    run_div("rem_negb", OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         32);
    run_div("div_by0",  OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 0);
    run_div("remu_by0", OP_REMU, 32'd5,         32'd0,         32'd5,         0);
    run_div("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_div("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);

    // backpressure: result held, new request ignored until out_ready returns
    out_ready = 1'b0;
    send("bp_add", OP_ADD, 32'd2, 32'd3, 32'd5, 0);
    in_valid = 1'b1;
    alu_ctrl = OP_SUB;
    op_a     = 32'd10;
    op_b     = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_result", result, 32'd5);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send("bp_sub", OP_SUB, 32'd10, 32'd3, 32'd7, 1);
    repeat (2) @(posedge clk);
    #1;

    // reset in the middle of a divide aborts it
    send("rst_div", OP_DIV, 32'd100, 32'd7, 32'd14, 33);
    repeat (9) @(posedge clk);
    #1;
    check("mid_div_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    tag_q.delete();
    lat_q.delete();
    acc_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    send("post_rst_add", OP_ADD, 32'd1, 32'd1, 32'd2, 1);
    repeat (3) @(posedge clk);
    #1;

    check("all_outputs_seen", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU for the RV32IM core. It consumes the 5-bit ALU control code produced by the ALU control decoder, together with two operands already selected by the ALUSrc mux. It returns a registered result plus zero flag over a valid/ready handshake toward the writeback/branch logic. Simple and multiply ops complete in one cycle; DIV/DIVU/REM/REMU use an iterative radix-2 divider.

## Interface
- DATA_WIDTH, 32, operand/result width; shift amount uses op_b[log2(DATA_WIDTH)-1:0]
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request this cycle
- alu_ctrl  in  5  operation code (encoding below)
- op_a  in  DATA_WIDTH  operand A (rs1)
- op_b  in  DATA_WIDTH  operand B (rs2 or immediate)
- out_valid  out  1  result/zero valid
- out_ready  in  1  consumer takes result this cycle
- result  out  DATA_WIDTH  registered result
- zero  out  1  registered (result == 0)
- busy  out  1  divider iterating (state DIV_RUN)

## Operation
- Encoding: 00000 ADD, 00001 SUB, 00010 MUL (low), 00011 MULH (s×s high), 00100 MULHSU (s×u high), 00101 MULHU (u×u high), 00110 DIV, 00111 DIVU, 01000 REM, 01001 REMU, 01010 XOR, 01011 OR, 01100 AND, 01101 SLL, 01110 SRL, 01111 SRA, 10000 SLT (signed, result 1/0), 10001 SLTU, 10010 EQ (1 if a==b), 10011 NE. Codes 10100–11111: result 0, single-cycle.
- ADD/SUB wrap modulo 2^DATA_WIDTH; multiplies form full 2·DATA_WIDTH product, select low or high half.
- Accept = in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- States: IDLE, DIV_RUN.
  - IDLE, accept of non-divide op, or divide special case: compute, load result/zero, set out_valid; stay IDLE.
  - IDLE, accept of normal divide: latch |dividend|, |divisor| (absolute values for DIV/REM, raw for DIVU/REMU), quotient/remainder sign flags, op kind; count=0; go DIV_RUN.
  - DIV_RUN: one restoring shift-subtract step per cycle; after step DATA_WIDTH-1, apply sign correction, load result, set out_valid, go IDLE.
- Divide special cases, handled single-cycle from IDLE:
  - divisor 0: DIV/DIVU → all-ones; REM/REMU → op_a.
  - DIV/REM with op_a = most-negative, op_b = −1: DIV → op_a; REM → 0.
- Signs: quotient negative iff operand signs differ; remainder takes sign of dividend.
- Output hold: while out_valid && !out_ready, result/zero/out_valid stable.
- out_valid clears on out_ready unless a new single-cycle result loads on the same edge.
- A divide in flight does not look at in_valid.

## Timing
- Reset (async): state IDLE, out_valid 0, result 0, zero 0, busy 0, count 0; in_ready 1 once reset deasserts.
- Reset mid-divide aborts the operation; no result is produced.
- Single-cycle ops: accepted at edge E0 → out_valid, result valid after E0 (latency 1). Back-to-back accepts every cycle if out_ready held high.
- Normal divide: accepted at E0; busy high after E0; steps at E1..E32; out_valid/result after E32 (latency DATA_WIDTH+1 = 33). busy low after E32. in_ready low from E0 until out_valid is consumed or out_ready high.
- Simultaneous out_ready and accept: old result retires; new result (single-cycle) replaces it on the same edge. For a normal divide, out_valid drops on that edge.
- in_ready and busy are combinational from registered state only (no in_valid path).

## Test plan
- Reset then ADD 7+(-3), SUB 5-5, SRA 0x80000000 by 4, SLTU 1 vs 0xFFFFFFFF → 4 (zero 0); 0 (zero 1); 0xF8000000; 1. Each has out_valid one cycle after accept, with back-to-back issue.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MUL low → 1.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2. Each out_valid exactly 33 cycles after accept, busy high 32 cycles, in_ready low throughout.
- Special cases: DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/−1 → 0x80000000; REM → 0. All latency 1, busy never asserted.
- Backpressure: out_ready low 5 cycles after an ADD → result stable, in_ready low, new in_valid ignored. Raise out_ready with in_valid → new result on the next edge, no lost or duplicated outputs.
- Reset asserted at divide step 10 → out_valid 0, busy 0 immediately. After release, a following ADD 1+1 returns 2 with latency 1.
